// File: rtl/lorenz_step_sched.sv
// Euler-step sequencer for the fixed-point Lorenz solver. One shared signed
// multiplier is time-multiplexed over the four per-step products. The x/y/z
// update is then committed in a single cycle.
module lorenz_step_sched #(
  parameter int unsigned N        = 32,
  parameter int unsigned FRAC     = 25,
  parameter int unsigned DT_SHIFT = 8,
  parameter int unsigned STEPW    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [STEPW-1:0] num_steps,
  input  logic [N-1:0]     sigma,
  input  logic [N-1:0]     beta,
  input  logic [N-1:0]     rho,
  input  logic [N-1:0]     x0,
  input  logic [N-1:0]     y0,
  input  logic [N-1:0]     z0,
  output logic [N-1:0]     x,
  output logic [N-1:0]     y,
  output logic [N-1:0]     z,
  output logic [STEPW-1:0] step_cnt,
  output logic             step_valid,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  typedef enum logic [2:0] {StIdle, StMul0, StMul1, StMul2, StMul3, StUpd} state_e;

  state_e                  state_q, state_d;
  logic signed [N-1:0]     x_q, x_d, y_q, y_d, z_q, z_d;
  logic signed [N-1:0]     sigma_q, sigma_d, beta_q, beta_d, rho_q, rho_d;
  logic signed [N-1:0]     p1_q, p1_d, p2_q, p2_d, p3_q, p3_d, p4_q, p4_d;
  logic [STEPW-1:0]        nsteps_q, nsteps_d, step_cnt_q, step_cnt_d;
  logic                    step_valid_q, step_valid_d, busy_q, busy_d;
  logic                    done_q, done_d, ovf_q, ovf_d;

  // Wrap-around signed overflow detection on a result already computed.
  function automatic logic add_ovf(logic [N-1:0] a, logic [N-1:0] b, logic [N-1:0] s);
    return (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  function automatic logic sub_ovf(logic [N-1:0] a, logic [N-1:0] b, logic [N-1:0] s);
    return (a[N-1] != b[N-1]) && (s[N-1] != a[N-1]);
  endfunction

  logic signed [N-1:0]     dtx, dty, dtz, d_yx, d_rz, q2, q3, x_new, y_new, z_new;
  logic signed [N-1:0]     mul_a, mul_b, mul_p;
  logic [2*N-1:0]          m;
  logic [N-FRAC:0]         m_hi;
  logic                    mul_ovf;
  logic                    unused_m_lo;
  logic [STEPW-1:0]        cnt_inc;

  assign dtx   = x_q >>> DT_SHIFT;
  assign dty   = y_q >>> DT_SHIFT;
  assign dtz   = z_q >>> DT_SHIFT;
  assign d_yx  = dty - dtx;
  assign d_rz  = rho_q - z_q;
  assign q2    = p2_q - dty;
  assign q3    = p3_q - p4_q;
  assign x_new = x_q + p1_q;
  assign y_new = y_q + q2;
  assign z_new = z_q + q3;
  assign cnt_inc = step_cnt_q + STEPW'(1);

  // Operand select for the shared multiplier, one product per MULk state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StMul0:  begin mul_a = d_yx; mul_b = sigma_q; end
      StMul1:  begin mul_a = dtx;  mul_b = d_rz;    end
      StMul2:  begin mul_a = x_q;  mul_b = dty;     end
      StMul3:  begin mul_a = dtz;  mul_b = beta_q;  end
      default: begin mul_a = '0;   mul_b = '0;      end
    endcase
  end

  // Sign-extended operands make the unsigned 2N-bit product equal the signed one.
  assign m           = {{N{mul_a[N-1]}}, mul_a} * {{N{mul_b[N-1]}}, mul_b};
  assign mul_p       = {m[2*N-1], m[N+FRAC-2:FRAC]};
  assign m_hi        = m[2*N-1:N+FRAC-1];
  assign mul_ovf     = !((&m_hi) || (m_hi == '0));
  assign unused_m_lo = ^m[FRAC-1:0];

  // Next-state: abort wins over start and over step progress.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    z_d          = z_q;
    sigma_d      = sigma_q;
    beta_d       = beta_q;
    rho_d        = rho_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    p3_d         = p3_q;
    p4_d         = p4_q;
    nsteps_d     = nsteps_q;
    step_cnt_d   = step_cnt_q;
    step_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    ovf_d        = ovf_q;
    if (abort) begin
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_steps != '0) begin
              sigma_d    = sigma;
              beta_d     = beta;
              rho_d      = rho;
              x_d        = x0;
              y_d        = y0;
              z_d        = z0;
              nsteps_d   = num_steps;
              step_cnt_d = '0;
              ovf_d      = 1'b0;
              busy_d     = 1'b1;
              state_d    = StMul0;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StMul0: begin
          p1_d    = mul_p;
          ovf_d   = ovf_q | mul_ovf | sub_ovf(dty, dtx, d_yx);
          state_d = StMul1;
        end
        StMul1: begin
          p2_d    = mul_p;
          ovf_d   = ovf_q | mul_ovf | sub_ovf(rho_q, z_q, d_rz);
          state_d = StMul2;
        end
        StMul2: begin
          p3_d    = mul_p;
          ovf_d   = ovf_q | mul_ovf;
          state_d = StMul3;
        end
        StMul3: begin
          p4_d    = mul_p;
          ovf_d   = ovf_q | mul_ovf;
          state_d = StUpd;
        end
        StUpd: begin
          x_d          = x_new;
          y_d          = y_new;
          z_d          = z_new;
          ovf_d        = ovf_q | sub_ovf(p2_q, dty, q2) | sub_ovf(p3_q, p4_q, q3)
                       | add_ovf(x_q, p1_q, x_new) | add_ovf(y_q, q2, y_new)
                       | add_ovf(z_q, q3, z_new);
          step_cnt_d   = cnt_inc;
          step_valid_d = 1'b1;
          if (cnt_inc == nsteps_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StMul0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      z_q          <= '0;
      sigma_q      <= '0;
      beta_q       <= '0;
      rho_q        <= '0;
      p1_q         <= '0;
      p2_q         <= '0;
      p3_q         <= '0;
      p4_q         <= '0;
      nsteps_q     <= '0;
      step_cnt_q   <= '0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      z_q          <= z_d;
      sigma_q      <= sigma_d;
      beta_q       <= beta_d;
      rho_q        <= rho_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      p3_q         <= p3_d;
      p4_q         <= p4_d;
      nsteps_q     <= nsteps_d;
      step_cnt_q   <= step_cnt_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign z          = z_q;
  assign step_cnt   = step_cnt_q;
  assign step_valid = step_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;

endmodule
